present_key_sched: RTL and testbench

- Sequential PRESENT key-schedule engine. Holds the working key register, iterates the key update once per round, and streams the 32 64-bit round keys to the round datapath over a valid/ready handshake.
- Supports 80-bit and 128-bit keys, selected by parameter.
- Upstream: the master-key loader. Downstream: the cipher round engine (addRoundKey).

---
 rtl/present_key_sched.sv | 118 +++++++++++
 tb/tb_present_key_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_key_sched.sv
// PRESENT key-schedule engine: loads an 80- or 128-bit master key and streams
// the 32 round keys K1..K32 over a valid/ready handshake, one update per transfer.
module present_key_sched #(
  parameter int KEY_SIZE = 80,
  parameter int NUM_RK   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_SIZE-1:0] key_in,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic                abort,
  output logic [63:0]         rk,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [4:0]          rk_idx,
  output logic                done
);

  generate
    if (KEY_SIZE != 80 && KEY_SIZE != 128) begin : g_bad_key_size
      $error("present_key_sched: KEY_SIZE must be 80 or 128");
    end
  endgenerate

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [4:0] LAST_IDX = 5'(NUM_RK - 1);
  // Lowest bit of the 5-bit round-counter XOR field for each key size.
  localparam int XOR_LO = (KEY_SIZE == 128) ? 62 : 15;

  logic [0:0]          state_q, state_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [4:0]          idx_q, idx_d;
  logic                done_q, done_d;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;
      4'h1: sbox = 4'h5;
      4'h2: sbox = 4'h6;
      4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;
      4'h5: sbox = 4'h0;
      4'h6: sbox = 4'hA;
      4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;
      4'h9: sbox = 4'hE;
      4'hA: sbox = 4'hF;
      4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;
      4'hD: sbox = 4'h7;
      4'hE: sbox = 4'h1;
      default: sbox = 4'h2;
    endcase
  endfunction

  // S-box and counter XOR act on the already rotated key.
  function automatic logic [KEY_SIZE-1:0] key_update(input logic [KEY_SIZE-1:0] k,
                                                     input logic [4:0]          c);
    logic [KEY_SIZE-1:0] r;
    r = {k[KEY_SIZE-62:0], k[KEY_SIZE-1:KEY_SIZE-61]};
    r[KEY_SIZE-1 -: 4] = sbox(r[KEY_SIZE-1 -: 4]);
    if (KEY_SIZE == 128) begin
      r[KEY_SIZE-5 -: 4] = sbox(r[KEY_SIZE-5 -: 4]);
    end
    r[XOR_LO +: 5] = r[XOR_LO +: 5] ^ c;
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (key_valid && !abort) begin
        key_d   = key_in;
        idx_d   = 5'd0;
        state_d = RUN;
      end
    end else if (abort) begin
      state_d = IDLE;
      idx_d   = 5'd0;
    end else if (rk_ready) begin
      // The last transfer retires the schedule without a further key update.
      if (idx_q == LAST_IDX) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        key_d = key_update(key_q, idx_q + 5'd1);
        idx_d = idx_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign rk        = key_q[KEY_SIZE-1 -: 64];
  assign rk_valid  = (state_q == RUN);
  assign key_ready = (state_q == IDLE);
  assign rk_idx    = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_present_key_sched.sv
// Bench for present_key_sched: an 80-bit and a 128-bit instance share the
// stimulus; a scoreboard of round keys from an independent model checks the stream.
module tb_present_key_sched;

  logic         clk;
  logic         rst_n;
  logic         sel;
  logic [127:0] key_w;
  logic         kv, ab, rr;

  logic [63:0] rk80, rk128;
  logic        kr80, kr128, rv80, rv128, done80, done128;
  logic [4:0]  idx80, idx128;

  logic [63:0] o_rk;
  logic        o_kr, o_rv, o_done;
  logic [4:0]  o_idx;

  int tests_run = 0;
  int fails     = 0;

  logic [68:0] sb[$];
  logic [63:0] exp_rk[32];

  present_key_sched #(.KEY_SIZE(80), .NUM_RK(32)) dut80 (
    .clk(clk), .rst_n(rst_n), .key_in(key_w[79:0]), .key_valid(kv & ~sel),
    .key_ready(kr80), .abort(ab & ~sel), .rk(rk80), .rk_valid(rv80),
    .rk_ready(rr & ~sel), .rk_idx(idx80), .done(done80)
  );

  present_key_sched #(.KEY_SIZE(128), .NUM_RK(32)) dut128 (
    .clk(clk), .rst_n(rst_n), .key_in(key_w), .key_valid(kv & sel),
    .key_ready(kr128), .abort(ab & sel), .rk(rk128), .rk_valid(rv128),
    .rk_ready(rr & sel), .rk_idx(idx128), .done(done128)
  );

  assign o_rk   = sel ? rk128   : rk80;
  assign o_kr   = sel ? kr128   : kr80;
  assign o_rv   = sel ? rv128   : rv80;
  assign o_done = sel ? done128 : done80;
  assign o_idx  = sel ? idx128  : idx80;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] sb4(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'hC56B90AD3EF84712;
    return tbl[60 - 4*x +: 4];
  endfunction

  function automatic logic [127:0] upd(input logic [127:0] k, input int ks, input logic [4:0] c);
    logic [79:0]  a;
    logic [127:0] b;
    a = k[79:0];
    b = k;
    if (ks == 80) begin
      a = (a << 61) | (a >> 19);
      a[79:76] = sb4(a[79:76]);
      a[19:15] = a[19:15] ^ c;
      return {48'd0, a};
    end
    b = (b << 61) | (b >> 67);
    b[127:124] = sb4(b[127:124]);
    b[123:120] = sb4(b[123:120]);
    b[66:62]   = b[66:62] ^ c;
    return b;
  endfunction

  task automatic gen_push(input logic [127:0] key, input int ks);
    logic [127:0] k;
    k = key;
    for (int i = 0; i < 32; i++) begin
      exp_rk[i] = (ks == 80) ? k[79:16] : k[127:64];
      sb.push_back({5'(i), exp_rk[i]});
      if (i < 31) k = upd(k, ks, 5'(i + 1));
    end
  endtask

  task automatic load(input logic [127:0] key);
    key_w = key;
    kv    = 1'b1;
    gen_push(key, sel ? 128 : 80);
    @(negedge clk);
    kv = 1'b0;
    tests_run++;
    if (o_rv !== 1'b1 || o_kr !== 1'b0) begin
      fails++;
      $display("FAIL load_handshake: rk_valid=%b key_ready=%b, required 1/0", o_rv, o_kr);
    end
  endtask

  // Called at a negedge in RUN; streams until 32 transfers, ends one cycle after done.
  task automatic stream(input int chk_const, input int mode);
    int          cyc = 0;
    int          got = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_rk;
    logic [4:0]  prev_idx;
    logic [68:0] e;
    logic [63:0] c80[3];
    logic [63:0] c128[2];
    c80[0]  = 64'h0000000000000000;
    c80[1]  = 64'hC000000000000000;
    c80[2]  = 64'h5000180000000001;
    c128[0] = 64'h0000000000000000;
    c128[1] = 64'hCC00000000000000;
    prev_rk  = '0;
    prev_idx = '0;
    while (got < 32 && cyc < 300) begin
      rr = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      tests_run++;
      if (o_done !== 1'b0) begin
        fails++;
        $display("FAIL done_early: done=%b at idx %0d, required 0", o_done, o_idx);
      end
      if (prev_stall) begin
        tests_run++;
        if (o_rk !== prev_rk || o_idx !== prev_idx) begin
          fails++;
          $display("FAIL hold: rk=%h idx=%0d, required rk=%h idx=%0d", o_rk, o_idx, prev_rk, prev_idx);
        end
      end
      if (o_rv && rr) begin
        tests_run++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_empty: transfer idx=%0d rk=%h, required no transfer", o_idx, o_rk);
        end else begin
          e = sb.pop_front();
          if ({o_idx, o_rk} !== e) begin
            fails++;
            $display("FAIL round_key: idx=%0d rk=%h, required idx=%0d rk=%h", o_idx, o_rk, e[68:64], e[63:0]);
          end
        end
        if (chk_const == 1 && got < 3) begin
          tests_run++;
          if (o_rk !== c80[got]) begin
            fails++;
            $display("FAIL k80_vector: idx=%0d rk=%h, required %h", got, o_rk, c80[got]);
          end
        end
        if (chk_const == 2 && got < 2) begin
          tests_run++;
          if (o_rk !== c128[got]) begin
            fails++;
            $display("FAIL k128_vector: idx=%0d rk=%h, required %h", got, o_rk, c128[got]);
          end
        end
        got++;
      end
      prev_stall = o_rv && !rr;
      prev_rk    = o_rk;
      prev_idx   = o_idx;
      @(negedge clk);
      cyc++;
    end
    rr = 1'b0;
    tests_run++;
    if (got != 32) begin
      fails++;
      $display("FAIL stream_timeout: %0d transfers, required 32", got);
    end
    if (mode == 0) begin
      tests_run++;
      if (cyc != 32) begin
        fails++;
        $display("FAIL no_bubbles: %0d cycles, required 32", cyc);
      end
    end
    tests_run++;
    if (o_done !== 1'b1 || o_rv !== 1'b0 || o_kr !== 1'b1) begin
      fails++;
      $display("FAIL end_of_schedule: done=%b rk_valid=%b key_ready=%b, required 1/0/1", o_done, o_rv, o_kr);
    end
    @(negedge clk);
    tests_run++;
    if (o_done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse_width: done=%b, required 0", o_done);
    end
  endtask

  // Streams with rk_ready high until rk_idx reaches target, checking each transfer.
  task automatic advance_to(input logic [4:0] target);
    int          cyc = 0;
    logic [68:0] e;
    rr = 1'b1;
    while (o_idx != target && cyc < 64) begin
      if (o_rv && sb.size() != 0) begin
        e = sb.pop_front();
        tests_run++;
        if ({o_idx, o_rk} !== e) begin
          fails++;
          $display("FAIL partial_key: idx=%0d rk=%h, required idx=%0d rk=%h", o_idx, o_rk, e[68:64], e[63:0]);
        end
      end
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (o_idx !== target) begin
      fails++;
      $display("FAIL advance_timeout: idx=%0d, required %0d", o_idx, target);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (rk80 !== 64'd0 || rv80 !== 1'b0 || idx80 !== 5'd0 || kr80 !== 1'b1 || done80 !== 1'b0) begin
      fails++;
      $display("FAIL reset80: rk=%h rv=%b idx=%0d kr=%b done=%b, required 0/0/0/1/0", rk80, rv80, idx80, kr80, done80);
    end
    tests_run++;
    if (rk128 !== 64'd0 || rv128 !== 1'b0 || idx128 !== 5'd0 || kr128 !== 1'b1 || done128 !== 1'b0) begin
      fails++;
      $display("FAIL reset128: rk=%h rv=%b idx=%0d kr=%b done=%b, required 0/0/0/1/0", rk128, rv128, idx128, kr128, done128);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    load(128'd0);
    stream(1, 0);
  endtask

  task automatic test_stall();
    sel = 1'b0;
    load(128'd0);
    stream(1, 1);
  endtask

  task automatic test_abort();
    sel = 1'b0;
    load(128'd0);
    advance_to(5'd10);
    ab = 1'b1;
    rr = 1'b1;
    @(negedge clk);
    ab = 1'b0;
    rr = 1'b0;
    sb.delete();
    tests_run++;
    if (o_rv !== 1'b0 || o_kr !== 1'b1 || o_idx !== 5'd0 || o_done !== 1'b0) begin
      fails++;
      $display("FAIL abort: rv=%b kr=%b idx=%0d done=%b, required 0/1/0/0", o_rv, o_kr, o_idx, o_done);
    end
    ab    = 1'b1;
    kv    = 1'b1;
    key_w = 128'h1234;
    @(negedge clk);
    ab = 1'b0;
    kv = 1'b0;
    tests_run++;
    if (o_rv !== 1'b0 || o_kr !== 1'b1) begin
      fails++;
      $display("FAIL abort_blocks_load: rv=%b kr=%b, required 0/1", o_rv, o_kr);
    end
    load(128'd0);
    stream(1, 0);
  endtask

  task automatic test_async_reset();
    sel = 1'b0;
    load({48'd0, $urandom, $urandom, 16'h5a5a});
    advance_to(5'd5);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (o_rv !== 1'b0 || o_kr !== 1'b1 || o_rk !== 64'd0 || o_idx !== 5'd0 || o_done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: rv=%b kr=%b rk=%h idx=%0d done=%b, required 0/1/0/0/0", o_rv, o_kr, o_rk, o_idx, o_done);
    end
    rr = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_key_valid_held();
    logic [127:0] key_b;
    sel   = 1'b0;
    key_b = {48'd0, 16'hbeef, $urandom, $urandom};
    load({48'd0, 16'h0f0f, $urandom, $urandom});
    kv    = 1'b1;
    key_w = key_b;
    stream(0, 0);
    gen_push(key_b, 80);
    kv = 1'b0;
    tests_run++;
    if (o_rv !== 1'b1 || o_rk !== exp_rk[0] || o_idx !== 5'd0) begin
      fails++;
      $display("FAIL reload_after_done: rv=%b rk=%h idx=%0d, required 1/%h/0", o_rv, o_rk, o_idx, exp_rk[0]);
    end
    stream(0, 0);
  endtask

  task automatic test_key128();
    sel = 1'b1;
    load(128'd0);
    stream(2, 0);
    load({$urandom, $urandom, $urandom, $urandom});
    stream(0, 1);
    sel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 1'b0;
    key_w = '0;
    kv    = 1'b0;
    ab    = 1'b0;
    rr    = 1'b0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_abort();
    test_async_reset();
    test_key_valid_held();
    test_key128();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
